l1_refill_ctrl: RTL and testbench
=================================

// Module: l1_refill_ctrl
// PURPOSE
//  Direct-mapped, write-through, no-write-allocate L1 data cache controller.
//  Sits between the core's dmem port and the backing memory model.
//  Replaces the zero-latency array with real hit/miss timing:
//  - core_wait is driven from actual tag lookups.
//  - Misses refill a full line over a req/ack handshake to backing memory.
// PARAMETERS
//  LINES           16  number of cache lines; power of 2, >=2
//  WORDS_PER_LINE  4   32-bit words per line; power of 2, >=2
//  Derived: OFF_W=log2(WORDS_PER_LINE), IDX_W=log2(LINES), TAG_W=30-OFF_W-IDX_W
// PORTS
//  clk            in   1   single clock; all state updates on posedge
//  reset          in   1   synchronous, active-high
//  core_req       in   1   core data access valid this cycle
//  core_we        in   1   1=store, 0=load (valid with core_req)
//  core_addr      in   32  byte address; [1:0] ignored
//  core_wdata     in   32  store data
//  core_rdata     out  32  load data; valid when core_req & !core_we & !core_wait
//  core_wait      out  1   stall core; core holds req/we/addr/wdata stable while 1
//  mem_req        out  1   backing-memory request
//  mem_we         out  1   backing-memory write
//  mem_addr       out  32  word-aligned backing-memory address
//  mem_wdata      out  32  backing-memory write data
//  mem_rdata      in   32  backing-memory read data, valid in ack cycle
//  mem_ack        in   1   transfer completes at posedge where mem_req & mem_ack
//  hit_count      out  32  load hits, wrap-around counter
//  miss_count     out  32  load misses, wrap-around counter
// BEHAVIOUR
//  Address split:
//   offset = addr[OFF_W+1:2]
//   index  = addr[IDX_W+OFF_W+1:OFF_W+2]
//   tag    = addr[31:IDX_W+OFF_W+2]
//   hit    = valid[index] & (tag_arr[index]==tag)
//  FSM states: IDLE, REFILL, WRITE.
//  IDLE:
//   - core_req=0: core_wait=0; no memory activity.
//   - Load hit: core_rdata=data[index][offset] combinationally; core_wait=0
//     same cycle; hit_count+1.
//   - Load miss: core_wait=1 same cycle; miss_count+1 (once per miss);
//     beat counter <- 0; next state REFILL.
//   - Store: core_wait=1; next state WRITE.
//  REFILL:
//   - mem_req=1, mem_we=0, mem_addr={tag,index,beat,2'b00}; core_wait=1.
//   - On ack: data[index][beat] <- mem_rdata; beat+1.
//   - Ack on last beat: valid[index]=1, tag_arr[index]=tag; next IDLE.
//   - Next cycle the retried lookup hits (counted as a hit).
//   - Latency: WORDS_PER_LINE acks + 2 cycles (miss detect + hit).
//   - One beat outstanding at a time.
//   - Ack may arrive in the same cycle mem_req rises (zero-wait memory).
//  WRITE:
//   - mem_req=1, mem_we=1, mem_addr={core_addr[31:2],2'b00},
//     mem_wdata=core_wdata.
//   - core_wait=1 until ack cycle; core_wait=0 in ack cycle; next IDLE.
//   - If the line hits, cached word updated at the ack edge.
//   - Store miss does not allocate (no valid/tag change).
//  Hold rule: mem_addr/mem_we/mem_wdata stay stable while mem_req=1 and no
//   ack. mem_req, mem_we, mem_addr and mem_wdata are 0 in IDLE.
//  Counters: 32-bit, wrap 0xFFFFFFFF->0; stores not counted.
//  Reset (any state): valid[] all 0, FSM=IDLE, beat=0, counters=0.
//   - Consequence: mem_req=0, core_wait=0 from the next cycle.
//   - Reset mid-REFILL abandons the line: it stays invalid; the partial data
//     is don't-care.
//   - Data/tag arrays are not reset.
//  Ack outside REFILL/WRITE is ignored. Ack with core_req=0 cannot occur
//   (core holds stable).
// TESTING
//  T1 reset, load 0x100, mem acks every cycle ->
//     4 reads at 0x100,0x104,0x108,0x10C;
//     core_wait=1 for 5 cycles, then rdata=MEM[0x100>>2]; miss=1, hit=1.
//  T2 after T1, loads 0x104,0x10C back-to-back ->
//     core_wait=0 both cycles, no mem_req; hit_count=3.
//  T3 store 0x108=0xDEADBEEF, ack after 3 cycles ->
//     mem_req/mem_we held 3 cycles, core_wait drops in ack cycle;
//     load 0x108 then hits with 0xDEADBEEF.
//  T4 store to miss 0x2000 then load 0x2000 ->
//     store does not allocate; load triggers a 4-beat refill from 0x2000.
//  T5 conflict 0x000 then 0x100 (LINES=16, same index 0) ->
//     second load misses and evicts; reload 0x000 misses again.
//  T6 reset asserted after 2nd refill beat ->
//     mem_req=0 next cycle, counters 0; reload of same addr misses again.

Source files
------------

// File: rtl/l1_refill_ctrl_if.sv
// l1_refill_ctrl_if
//   Bundles the core-side dmem port and the backing-memory port of the L1
//   data cache controller.
//   master : the environment (core plus backing memory). It drives the core request
//            and the memory response.
//   slave  : the cache controller. It drives the core response and the memory request.
//   Signals:
//     core_req/core_we/core_addr/core_wdata : core access request
//     core_rdata/core_wait                  : load data and core stall
//     mem_req/mem_we/mem_addr/mem_wdata     : backing-memory request
//     mem_rdata/mem_ack                     : backing-memory response
interface l1_refill_ctrl_if;
  logic        core_req;
  logic        core_we;
  logic [31:0] core_addr;
  logic [31:0] core_wdata;
  logic [31:0] core_rdata;
  logic        core_wait;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  modport master (
    output core_req, core_we, core_addr, core_wdata, mem_rdata, mem_ack,
    input  core_rdata, core_wait, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  core_req, core_we, core_addr, core_wdata, mem_rdata, mem_ack,
    output core_rdata, core_wait, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/l1_refill_ctrl.sv
// l1_refill_ctrl
//   Direct-mapped, write-through, no-write-allocate L1 data cache controller.
//   Load hits return data in the same cycle. A load miss refills the whole line,
//   one beat at a time over the req/ack handshake, and then retries the lookup.
//   A store is written through to backing memory and updates the cached word
//   only when the line is present.
//   Ports:
//     clk        : clock; all state updates on posedge
//     reset      : synchronous, active-high
//     bus        : l1_refill_ctrl_if.slave (core port + backing-memory port)
//     hit_count  : load hits, 32-bit wrap-around
//     miss_count : load misses, 32-bit wrap-around
module l1_refill_ctrl #(
  parameter int LINES          = 16,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  l1_refill_ctrl_if.slave        bus,
  output logic [31:0]            hit_count,
  output logic [31:0]            miss_count
);

  localparam int OFF_W = $clog2(WORDS_PER_LINE);
  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = 30 - OFF_W - IDX_W;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_REFILL = 2'd1;
  localparam logic [1:0] ST_WRITE  = 2'd2;

  localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(WORDS_PER_LINE - 1);
  localparam logic [OFF_W-1:0] BEAT_ONE  = OFF_W'(1);
  localparam logic [OFF_W-1:0] BEAT_ZERO = OFF_W'(0);

  logic [1:0]       state_r;
  logic [1:0]       state_nxt_s;
  logic [OFF_W-1:0] beat_r;
  logic [LINES-1:0] valid_r;
  logic [TAG_W-1:0] tag_arr_r [LINES];
  logic [31:0]      data_r    [LINES*WORDS_PER_LINE];
  logic [31:0]      hit_count_r;
  logic [31:0]      miss_count_r;

  logic [OFF_W-1:0] offset_s;
  logic [IDX_W-1:0] index_s;
  logic [TAG_W-1:0] tag_s;
  logic             hit_s;
  logic             last_ack_s;
  logic [31:0]      rd_word_s;
  logic             unused_addr_s;

  assign offset_s      = bus.core_addr[OFF_W+1:2];
  assign index_s       = bus.core_addr[IDX_W+OFF_W+1:OFF_W+2];
  assign tag_s         = bus.core_addr[31:IDX_W+OFF_W+2];
  assign hit_s         = valid_r[index_s] && (tag_arr_r[index_s] == tag_s);
  assign rd_word_s     = data_r[{index_s, offset_s}];
  assign last_ack_s    = bus.mem_ack && (beat_r == LAST_BEAT);
  assign unused_addr_s = ^bus.core_addr[1:0];

  assign hit_count  = hit_count_r;
  assign miss_count = miss_count_r;

  // Next-state decode plus combinational core and memory outputs.
  always_comb begin
    state_nxt_s    = state_r;
    bus.core_wait  = 1'b0;
    bus.core_rdata = rd_word_s;
    bus.mem_req    = 1'b0;
    bus.mem_we     = 1'b0;
    bus.mem_addr   = 32'd0;
    bus.mem_wdata  = 32'd0;
    case (state_r)
      ST_IDLE: begin
        if (bus.core_req) begin
          if (bus.core_we) begin
            bus.core_wait = 1'b1;
            state_nxt_s   = ST_WRITE;
          end else if (hit_s) begin
            bus.core_wait = 1'b0;
          end else begin
            bus.core_wait = 1'b1;
            state_nxt_s   = ST_REFILL;
          end
        end else begin
          bus.core_wait = 1'b0;
        end
      end
      ST_REFILL: begin
        bus.core_wait = 1'b1;
        bus.mem_req   = 1'b1;
        bus.mem_addr  = {tag_s, index_s, beat_r, 2'b00};
        if (last_ack_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_REFILL;
        end
      end
      ST_WRITE: begin
        bus.mem_req   = 1'b1;
        bus.mem_we    = 1'b1;
        bus.mem_addr  = {bus.core_addr[31:2], 2'b00};
        bus.mem_wdata = bus.core_wdata;
        // The store retires in the ack cycle, so the stall drops right there.
        bus.core_wait = !bus.mem_ack;
        if (bus.mem_ack) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_WRITE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // FSM state, beat counter, line valid bits and hit/miss counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      beat_r       <= BEAT_ZERO;
      valid_r      <= {LINES{1'b0}};
      hit_count_r  <= 32'd0;
      miss_count_r <= 32'd0;
    end else begin
      state_r <= state_nxt_s;
      case (state_r)
        ST_IDLE: begin
          if (bus.core_req && !bus.core_we) begin
            if (hit_s) begin
              hit_count_r <= hit_count_r + 32'd1;
            end else begin
              miss_count_r     <= miss_count_r + 32'd1;
              beat_r           <= BEAT_ZERO;
              // Drop the victim line while its words are overwritten.
              valid_r[index_s] <= 1'b0;
            end
          end
        end
        ST_REFILL: begin
          if (bus.mem_ack) begin
            beat_r <= beat_r + BEAT_ONE;
            if (beat_r == LAST_BEAT) begin
              valid_r[index_s] <= 1'b1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Tag and data arrays. They are not reset. A reset cycle only blocks writes.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state_r == ST_REFILL && bus.mem_ack) begin
        data_r[{index_s, beat_r}] <= bus.mem_rdata;
        if (beat_r == LAST_BEAT) begin
          tag_arr_r[index_s] <= tag_s;
        end
      end else if (state_r == ST_WRITE && bus.mem_ack && hit_s) begin
        data_r[{index_s, offset_s}] <= bus.core_wdata;
      end
    end
  end

endmodule

// File: tb/tb_l1_refill_ctrl.sv
// tb_l1_refill_ctrl
//   Self-checking bench for l1_refill_ctrl (LINES=16, WORDS_PER_LINE=4).
//   The backing-memory responder acks with a programmable delay. Expected load
//   data and expected memory transactions go onto scoreboard queues when
//   stimulus is driven. They are popped when the DUT completes the access.
module tb_l1_refill_ctrl;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  l1_refill_ctrl_if bus ();

  l1_refill_ctrl #(.LINES(16), .WORDS_PER_LINE(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .hit_count (hit_count),
    .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_txn_t;

  int          checks = 0;
  int          errors = 0;
  int          ack_delay = 0;
  bit          resp_en = 1'b1;
  int          acks_seen = 0;
  logic [31:0] ref_mem  [4096];
  logic [31:0] back_mem [4096];
  logic [31:0] exp_rd_q [$];
  mem_txn_t    exp_mem_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] init_word(input int i);
    return 32'hC0DE0000 | 32'(i);
  endfunction

  // Backing memory: it acks after ack_delay wait cycles and checks each transfer against the queue.
  initial begin
    int       wait_cnt;
    mem_txn_t t;
    wait_cnt = 0;
    for (int i = 0; i < 4096; i++) back_mem[i] = init_word(i);
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 32'd0;
    forever begin
      @(negedge clk);
      if (bus.mem_ack) begin
        bus.mem_ack = 1'b0;
        wait_cnt    = 0;
      end
      if (bus.mem_req && resp_en && !reset) begin
        if (wait_cnt >= ack_delay) begin
          if (exp_mem_q.size() == 0) begin
            check("mem_unexpected", 64'(bus.mem_addr), 64'hFFFF_FFFF_FFFF_FFFF);
          end else begin
            t = exp_mem_q.pop_front();
            check("mem_we_addr", {31'd0, bus.mem_we, bus.mem_addr}, {31'd0, t.we, t.addr});
            if (t.we) check("mem_wdata", 64'(bus.mem_wdata), 64'(t.wdata));
          end
          bus.mem_rdata = back_mem[bus.mem_addr[13:2]];
          if (bus.mem_we) back_mem[bus.mem_addr[13:2]] = bus.mem_wdata;
          bus.mem_ack = 1'b1;
          acks_seen++;
        end else begin
          wait_cnt++;
        end
      end
    end
  end

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  task automatic push_refill(input logic [31:0] addr);
    mem_txn_t t;
    for (int b = 0; b < 4; b++) begin
      t.we    = 1'b0;
      t.addr  = {addr[31:4], 4'h0} + 32'(b * 4);
      t.wdata = 32'd0;
      exp_mem_q.push_back(t);
    end
  endtask

  // Called just after a posedge. It returns just after a later posedge.
  task automatic do_load(input logic [31:0] addr, input bit exp_miss, input string tag);
    int waits;
    bit done;
    exp_rd_q.push_back(ref_mem[addr[13:2]]);
    if (exp_miss) push_refill(addr);
    bus.core_req   = 1'b1;
    bus.core_we    = 1'b0;
    bus.core_addr  = addr;
    bus.core_wdata = 32'd0;
    waits = 0;
    done  = 1'b0;
    for (int c = 0; c < 200 && !done; c++) begin
      sample();
      if (bus.core_wait) begin
        waits++;
      end else begin
        done = 1'b1;
        check({tag, "_rdata"}, 64'(bus.core_rdata), 64'(exp_rd_q.pop_front()));
      end
    end
    if (!done) begin
      check({tag, "_timeout"}, 64'(1), 64'(0));
      void'(exp_rd_q.pop_front());
    end
    check({tag, "_wait"}, 64'(waits), 64'(exp_miss ? 1 + 4 * (ack_delay + 1) : 0));
    @(posedge clk);
    #1;
    bus.core_req = 1'b0;
  endtask

  task automatic do_store(input logic [31:0] addr, input logic [31:0] data, input int delay,
                          input string tag);
    int       waits;
    bit       done;
    mem_txn_t t;
    ack_delay = delay;
    ref_mem[addr[13:2]] = data;
    t.we = 1'b1;
    t.addr = {addr[31:2], 2'b00};
    t.wdata = data;
    exp_mem_q.push_back(t);
    bus.core_req   = 1'b1;
    bus.core_we    = 1'b1;
    bus.core_addr  = addr;
    bus.core_wdata = data;
    waits = 0;
    done  = 1'b0;
    for (int c = 0; c < 200 && !done; c++) begin
      sample();
      if (bus.core_wait) begin
        waits++;
      end else begin
        done = 1'b1;
        check({tag, "_ack_cycle"}, 64'(bus.mem_ack), 64'(1));
      end
    end
    if (!done) check({tag, "_timeout"}, 64'(1), 64'(0));
    check({tag, "_wait"}, 64'(waits), 64'(1 + delay));
    @(posedge clk);
    #1;
    bus.core_req = 1'b0;
    bus.core_we  = 1'b0;
  endtask

  task automatic check_counts(input string tag, input int hits, input int misses);
    check({tag, "_hits"}, 64'(hit_count), 64'(hits));
    check({tag, "_misses"}, 64'(miss_count), 64'(misses));
  endtask

  task automatic check_idle(input string tag);
    sample();
    check({tag, "_wait"}, 64'(bus.core_wait), 64'(0));
    check({tag, "_mem"}, {bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata[29:0]}, 64'(0));
    @(posedge clk);
    #1;
  endtask

  // Main stimulus sequence
  initial begin
    int base;
    for (int i = 0; i < 4096; i++) ref_mem[i] = init_word(i);
    bus.core_req   = 1'b0;
    bus.core_we    = 1'b0;
    bus.core_addr  = 32'd0;
    bus.core_wdata = 32'd0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check_counts("rst", 0, 0);
    check_idle("rst_idle");

    // T1: cold miss, zero-wait memory
    ack_delay = 0;
    do_load(32'h0000_0100, 1'b1, "t1");
    check_counts("t1", 1, 1);

    // T2: back-to-back hits in the same line
    do_load(32'h0000_0104, 1'b0, "t2a");
    do_load(32'h0000_010C, 1'b0, "t2b");
    check_counts("t2", 3, 1);

    // T3: store hit with a slow ack, then read back
    do_store(32'h0000_0108, 32'hDEAD_BEEF, 3, "t3st");
    do_load(32'h0000_0108, 1'b0, "t3ld");
    check_counts("t3", 4, 1);

    // T4: store miss does not allocate
    do_store(32'h0000_2000, 32'h1234_5678, 0, "t4st");
    do_load(32'h0000_2000, 1'b1, "t4ld");
    check_counts("t4", 5, 2);

    // T5: conflict evictions on index 0, refill with one wait cycle per beat
    ack_delay = 1;
    do_load(32'h0000_0000, 1'b1, "t5a");
    do_load(32'h0000_0100, 1'b1, "t5b");
    do_load(32'h0000_0108, 1'b0, "t5d");
    do_load(32'h0000_0000, 1'b1, "t5c");
    do_store(32'h0000_0004, 32'h0BAD_F00D, 0, "t5st");
    do_load(32'h0000_0004, 1'b0, "t5e");
    check_counts("t5", 10, 5);
    check_idle("t5_idle");

    // T6: reset after the second refill beat
    ack_delay = 0;
    push_refill(32'h0000_0040);
    bus.core_req  = 1'b1;
    bus.core_we   = 1'b0;
    bus.core_addr = 32'h0000_0040;
    base = acks_seen;
    for (int c = 0; c < 50; c++) begin
      @(posedge clk);
      if (acks_seen - base >= 2) break;
    end
    #1;
    check("t6_beats", 64'(acks_seen - base), 64'(2));
    reset        = 1'b1;
    resp_en      = 1'b0;
    bus.core_req = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    sample();
    check("t6_mem_req", 64'(bus.mem_req), 64'(0));
    check("t6_wait", 64'(bus.core_wait), 64'(0));
    check_counts("t6_rst", 0, 0);
    check("t6_pending", 64'(exp_mem_q.size()), 64'(2));
    exp_mem_q.delete();
    resp_en = 1'b1;
    @(posedge clk);
    #1;
    do_load(32'h0000_0040, 1'b1, "t6re");
    check_counts("t6", 1, 1);

    check("mem_q_empty", 64'(exp_mem_q.size()), 64'(0));
    check("rd_q_empty", 64'(exp_rd_q.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
